// File: rtl/alu_result_queue.sv
// ============================================================================
// Module      : alu_result_queue
// Description : FIFO of adder results with derived {neg,zero,cout,ovf} flags.
//               Optional sticky ovf/cout status, enabled by STICKY_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_queue #(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_result,
  input  logic                     in_ovf,
  input  logic                     in_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_result,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_sticky,
  output logic                     sticky_ovf,
  output logic                     sticky_cout
);

  localparam int               c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0]    c_depth = (c_aw + 1)'(DEPTH);

  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            r_ready_en;
  logic [19:0]     r_mem [DEPTH];
  logic [19:0]     w_head;
  logic            w_push;
  logic            w_pop;

  // in_ready is held low until the first edge after reset release.
  assign in_ready  = r_ready_en && (r_count != c_depth);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry layout: {neg, zero, cout, ovf, result}; storage is not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_result[15], (in_result == 16'h0000), in_cout, in_ovf, in_result};
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign out_result = out_valid ? w_head[15:0]  : 16'h0000;
  assign out_flags  = out_valid ? w_head[19:16] : 4'b0000;

`ifdef STICKY_FLAGS_EN
  logic r_sticky_ovf;
  logic r_sticky_cout;

  // A setting push in the same cycle as clr_sticky takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_ovf  <= 1'b0;
      r_sticky_cout <= 1'b0;
    end else begin
      if (w_push && in_ovf)  r_sticky_ovf  <= 1'b1;
      else if (clr_sticky)   r_sticky_ovf  <= 1'b0;
      if (w_push && in_cout) r_sticky_cout <= 1'b1;
      else if (clr_sticky)   r_sticky_cout <= 1'b0;
    end
  end

  assign sticky_ovf  = r_sticky_ovf;
  assign sticky_cout = r_sticky_cout;
`else
  logic w_unused_sticky;
  assign w_unused_sticky = clr_sticky;
  assign sticky_ovf      = 1'b0;
  assign sticky_cout     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_queue.sv
// ============================================================================
// Module      : tb_alu_result_queue
// Description : Self-checking bench for alu_result_queue (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_ovf;
  logic        in_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic        clr_sticky;
  logic        sticky_ovf;
  logic        sticky_cout;

  alu_result_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_ovf(in_ovf), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .count(count),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .sticky_cout(sticky_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        cout;
    logic [3:0]  flags;  // expected {neg, zero, cout, ovf}
  } vec_t;

  vec_t        vecs [6];
  logic [19:0] sb [$];
  logic        m_ready_en;
  logic        m_sov;
  logic        m_scout;
  int          n_total;
  int          n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic check_state();
    logic [19:0] head;
    head = (sb.size() != 0) ? sb[0] : 20'h0;
    check("count",       32'(count),       32'(sb.size()));
    check("out_valid",   32'(out_valid),   32'(sb.size() != 0));
    check("in_ready",    32'(in_ready),    32'(m_ready_en && sb.size() < DEPTH));
    check("out_result",  32'(out_result),  32'(head[15:0]));
    check("out_flags",   32'(out_flags),   32'(head[19:16]));
    check("sticky_ovf",  32'(sticky_ovf),  32'(m_sov));
    check("sticky_cout", 32'(sticky_cout), 32'(m_scout));
  endtask

  // One clock cycle: verify current outputs, drive inputs, advance, update model.
  task automatic cycle(input logic iv, input logic [15:0] r, input logic o, input logic c,
                       input logic [3:0] fl, input logic ordy, input logic clr);
    logic acc, pop;
    check_state();
    in_valid = iv; in_result = r; in_ovf = o; in_cout = c;
    out_ready = ordy; clr_sticky = clr;
    acc = iv && m_ready_en && (sb.size() < DEPTH);
    pop = ordy && (sb.size() != 0);
    @(posedge clk);
    #1;
    if (pop) void'(sb.pop_front());
    if (acc) sb.push_back({fl, r});
`ifdef STICKY_FLAGS_EN
    if (acc && o) m_sov = 1'b1; else if (clr) m_sov = 1'b0;
    if (acc && c) m_scout = 1'b1; else if (clr) m_scout = 1'b0;
`endif
    m_ready_en = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_total = 0; n_pass = 0;
    m_ready_en = 1'b0; m_sov = 1'b0; m_scout = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_ovf = 1'b0; in_cout = 1'b0;
    out_ready = 1'b0; clr_sticky = 1'b0;

    vecs[0] = '{16'h7FFF, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{16'h0000, 1'b0, 1'b1, 4'b0110};
    vecs[2] = '{16'h8000, 1'b1, 1'b0, 4'b1001};
    vecs[3] = '{16'h1234, 1'b0, 1'b0, 4'b0000};
    vecs[4] = '{16'hFFFF, 1'b1, 1'b1, 4'b1011};
    vecs[5] = '{16'h0000, 1'b1, 1'b0, 4'b0101};

    // Reset state, and in_ready stays low until the first edge after release.
    #2 check_state();
    #10 rst_n = 1'b1;
    #1 check("in_ready_after_release", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    m_ready_en = 1'b1;

    // Table: push each vector with out_ready=0, then pop it.
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].res, vecs[i].ovf, vecs[i].cout, vecs[i].flags, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    end

    // Two pushes back to back, then pop both in order.
    cycle(1'b1, 16'h0000, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0);
    cycle(1'b1, 16'h8000, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Overfill: 1..5 with no pops; value 5 must be refused.
    for (int v = 1; v <= 5; v++)
      cycle(1'b1, 16'(v), 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    // Full with simultaneous pop: no push happens.
    cycle(1'b1, 16'h00AA, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    // Pop while empty is ignored.
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Steady state at count=2 with push and pop each cycle; pointers wrap.
    cycle(1'b1, 16'h0100, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(1'b1, 16'h0101, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int k = 2; k < 8; k++)
      cycle(1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Sticky: clear, then clear coinciding with an ovf push, then clear alone.
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    cycle(1'b1, 16'h4000, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

    // Async reset between edges with count=3.
    cycle(1'b1, 16'h0011, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
    cycle(1'b1, 16'h0022, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
    cycle(1'b1, 16'h0033, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("count_before_reset", 32'(count), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    sb.delete(); m_sov = 1'b0; m_scout = 1'b0; m_ready_en = 1'b0;
    check_state();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    m_ready_en = 1'b1;
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0044, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    check_state();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_result_queue.md
ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of result entries; it SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; reset SHALL be asynchronous and active-low.
REQ-004 in_valid  input  1  upstream adder result valid.
REQ-005 in_ready  output  1  queue can accept a result this cycle.
REQ-006 in_result  input  16  adder sum C.
REQ-007 in_ovf  input  1  adder overFlag.
REQ-008 in_cout  input  1  adder coutFlag.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_ready  input  1  downstream consumes head entry.
REQ-011 out_result  output  16  head entry result.
REQ-012 out_flags  output  4  head entry flags {neg, zero, cout, ovf}, bit 3 first.
REQ-013 count  output  log2(DEPTH)+1  entries currently stored.
REQ-014 clr_sticky  input  1  clear sticky status flags.
REQ-015 sticky_ovf  output  1  sticky overflow.
REQ-016 sticky_cout  output  1  sticky carry-out.

Function
REQ-017 Push SHALL occur on a rising edge where in_valid=1 and in_ready=1; pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL equal (count < DEPTH); out_valid SHALL equal (count != 0); both SHALL be derived from registered count only, with no combinational path from in_valid or out_ready.
REQ-019 On push, the entry SHALL store in_result, in_ovf, in_cout, zero = (in_result == 16'h0000), and neg = in_result[15], all captured at that edge.
REQ-020 out_result and out_flags SHALL reflect the oldest stored entry; they are valid only while out_valid=1 and SHALL be 0 when count=0.
REQ-021 Latency: a result pushed at edge N SHALL be visible at the outputs after edge N when the queue was empty (one-cycle latency, no fall-through in the same cycle).
REQ-022 Ordering SHALL be strict FIFO; write and read pointers SHALL wrap modulo DEPTH.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH: both SHALL occur, and count SHALL be unchanged.
REQ-024 Full (count=DEPTH): in_ready=0, so no push occurs even if a pop occurs in the same cycle; in_valid SHALL be ignored with the upstream result not consumed.
REQ-025 Empty (count=0): out_ready SHALL be ignored, and pointers and count SHALL be unchanged.
REQ-026 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or underflow.
REQ-027 sticky_ovf SHALL set on any push with in_ovf=1; sticky_cout SHALL set on any push with in_cout=1.
REQ-028 clr_sticky=1 SHALL clear both sticky flags at the edge; if a setting push coincides, set SHALL win for the affected flag.

Reset
REQ-029 rst_n=0 SHALL immediately force count=0, pointers=0, in_ready=0, out_valid=0, out_result=0, out_flags=0, sticky_ovf=0, sticky_cout=0, regardless of clk.
REQ-030 in_ready SHALL rise on the first rising edge after rst_n deasserts. Entry storage content need not be reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; no pop or push SHALL complete at that edge.

Configuration
REQ-032 Macro STICKY_FLAGS_EN: when defined, REQ-027 and REQ-028 SHALL apply as written.
REQ-033 When STICKY_FLAGS_EN is undefined, sticky_ovf and sticky_cout SHALL be constant 0, clr_sticky SHALL be ignored, and no sticky registers SHALL be synthesized; the ports SHALL remain present.

Verification
REQ-034 Reset then push 16'h7FFF with ovf=0 and cout=0, with out_ready=0 -> next cycle out_valid=1, out_result=16'h7FFF, out_flags=4'b0000, count=1.
REQ-035 Push 16'h0000 with cout=1, then 16'h8000 with ovf=1, then pop both -> out_flags 4'b0110 then 4'b1001, in order; with the macro defined, sticky_ovf=1 and sticky_cout=1.
REQ-036 Push 5 values 1..5 at DEPTH=4 with out_ready=0 -> count=4, in_ready=0 after the fourth push, value 5 not accepted; then pop all -> outputs 1,2,3,4.
REQ-037 With count=2, hold in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, outputs in push order, pointers wrap correctly.
REQ-038 Assert clr_sticky in the same cycle as a push with in_ovf=1 -> sticky_ovf=1 afterwards; clr_sticky alone next cycle -> sticky_ovf=0.
REQ-039 Drop rst_n asynchronously between edges with count=3 -> count=0, out_valid=0, and sticky flags 0 immediately; after release, pops yield nothing until a new push.
